ttt_result_scanner: RTL and testbench

Sequential, parametrised game-result checker for an N×N board where K marks in a row win. It generalises the fixed 3×3 combinational win/tie decoder. On `start` it snapshots the board, then scans one anchor cell per clock. It reports no-result / player-1 / player-2 / tie through a start/busy/done handshake, and sits between the board register file and the game-control FSM.

---
 rtl/ttt_result_scanner.sv | 234 +++++++++++++++++++++++
 tb/tb_ttt_result_scanner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : ttt_result_scanner
// Purpose  : Sequential game-result checker for an N x N board where K marks
//            in a row win. A start request snapshots the board, then one
//            anchor cell is examined per clock (lines right, down, down-right,
//            down-left). The result is reported through start/busy/done.
// Params   : N (3..8) board side, K (3..N) winning run length.
// Ports    : clk      - clock, rising edge
//            rst_n    - synchronous active-low reset
//            start    - scan request, accepted only when idle
//            board    - flattened board, cell i=row*N+col at [2i+1:2i]
//                       (00 empty, 01 P1, 10 P2, 11 invalid)
//            busy     - scan in progress (through the done cycle)
//            done     - one-cycle completion pulse
//            status   - 00 none, 01 P1 win, 10 P2 win, 11 tie (held)
//            win_cell - anchor cell of winning line   (macro only)
//            win_dir  - 00 right, 01 down, 10 dr, 11 dl (macro only)
// Macro    : TTT_RESULT_LINE_REPORT_EN enables win_cell / win_dir.
// Revision : 1.0 - initial release
// ============================================================================
module ttt_result_scanner #(
    parameter int N = 3,
    parameter int K = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*N*N-1:0]        board,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              status
`ifdef TTT_RESULT_LINE_REPORT_EN
    ,
    output logic [$clog2(N*N)-1:0]  win_cell,
    output logic [1:0]              win_dir
`endif
);

    localparam int c_CELLS = N * N;
    localparam int c_IW    = $clog2(c_CELLS);
    localparam int c_RW    = $clog2(N);

    if ((N < 3) || (N > 8) || (K < 3) || (K > N)) begin : g_bad_param
        $error("ttt_result_scanner: illegal N/K combination");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2*N*N-1:0]   snap_q, snap_d;
    logic [c_IW-1:0]    idx_q, idx_d;
    logic [c_RW-1:0]    row_q, row_d;
    logic [c_RW-1:0]    col_q, col_d;
    logic               empty_q, empty_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         status_q, status_d;
`ifdef TTT_RESULT_LINE_REPORT_EN
    logic [c_IW-1:0]    win_cell_q, win_cell_d;
    logic [1:0]         win_dir_q, win_dir_d;
    logic [1:0]         win_dir_sel;
`endif

    logic [1:0]         anchor;
    logic               win_found;

    // Out-of-board coordinates match no cell and read as empty; callers
    // only rely on in-board reads because line bounds are checked first.
    function automatic logic [1:0] cell_at(input logic [2*N*N-1:0] b,
                                           input int r, input int c);
        cell_at = 2'b00;
        for (int i = 0; i < c_CELLS; i++) begin
            if ((r >= 0) && (r < N) && (c >= 0) && (c < N) && (i == r * N + c))
                cell_at = b[2*i +: 2];
        end
    endfunction

    // Line evaluation at the current anchor. Every line contains the anchor,
    // so a line wins when the anchor holds a player mark and the remaining
    // K-1 cells match it.
    always_comb begin : p_eval
        int   r;
        int   c;
        int   dr;
        int   dc;
        logic hit;
        r         = int'(row_q);
        c         = int'(col_q);
        dr        = 0;
        dc        = 0;
        hit       = 1'b0;
        win_found = 1'b0;
`ifdef TTT_RESULT_LINE_REPORT_EN
        win_dir_sel = 2'b00;
`endif
        anchor = cell_at(snap_q, r, c);
        for (int d = 0; d < 4; d++) begin
            case (d)
                0:       begin dr = 0; dc = 1;  end
                1:       begin dr = 1; dc = 0;  end
                2:       begin dr = 1; dc = 1;  end
                default: begin dr = 1; dc = -1; end
            endcase
            hit = ((anchor == 2'b01) || (anchor == 2'b10))
                  && (r + dr * (K - 1) <= N - 1)
                  && (c + dc * (K - 1) >= 0)
                  && (c + dc * (K - 1) <= N - 1);
            for (int s = 1; s < K; s++) begin
                if (cell_at(snap_q, r + dr * s, c + dc * s) != anchor)
                    hit = 1'b0;
            end
            if (hit && !win_found) begin
                win_found = 1'b1;
`ifdef TTT_RESULT_LINE_REPORT_EN
                win_dir_sel = 2'(d);
`endif
            end
        end
    end

    always_comb begin : p_next
        state_d  = state_q;
        snap_d   = snap_q;
        idx_d    = idx_q;
        row_d    = row_q;
        col_d    = col_q;
        empty_d  = empty_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        status_d = status_q;
`ifdef TTT_RESULT_LINE_REPORT_EN
        win_cell_d = win_cell_q;
        win_dir_d  = win_dir_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    snap_d   = board;
                    idx_d    = '0;
                    row_d    = '0;
                    col_d    = '0;
                    empty_d  = 1'b0;
                    busy_d   = 1'b1;
                    status_d = 2'b00;
                end
            end
            ST_SCAN: begin
                if (win_found) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    status_d = anchor;
`ifdef TTT_RESULT_LINE_REPORT_EN
                    win_cell_d = idx_q;
                    win_dir_d  = win_dir_sel;
`endif
                end else if (idx_q == c_IW'(c_CELLS - 1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    // The last anchor's own emptiness has not yet been folded in.
                    status_d = (empty_q || (anchor == 2'b00)) ? 2'b00 : 2'b11;
`ifdef TTT_RESULT_LINE_REPORT_EN
                    win_cell_d = '0;
                    win_dir_d  = 2'b00;
`endif
                end else begin
                    idx_d   = idx_q + c_IW'(1);
                    empty_d = empty_q || (anchor == 2'b00);
                    if (col_q == c_RW'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + c_RW'(1);
                    end else begin
                        col_d = col_q + c_RW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            snap_q   <= '0;
            idx_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            empty_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            status_q <= 2'b00;
`ifdef TTT_RESULT_LINE_REPORT_EN
            win_cell_q <= '0;
            win_dir_q  <= 2'b00;
`endif
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            idx_q    <= idx_d;
            row_q    <= row_d;
            col_q    <= col_d;
            empty_q  <= empty_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            status_q <= status_d;
`ifdef TTT_RESULT_LINE_REPORT_EN
            win_cell_q <= win_cell_d;
            win_dir_q  <= win_dir_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;
`ifdef TTT_RESULT_LINE_REPORT_EN
    assign win_cell = win_cell_q;
    assign win_dir  = win_dir_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ttt_result_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttt_result_scanner
// Purpose  : Directed self-checking bench for ttt_result_scanner, with a
//            3x3/K=3 instance and a 5x5/K=4 instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttt_result_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start3, start5;
    logic [17:0] board3;
    logic [49:0] board5;
    logic        busy3, done3, busy5, done5;
    logic [1:0]  status3, status5;
`ifdef TTT_RESULT_LINE_REPORT_EN
    logic [3:0]  win_cell3;
    logic [1:0]  win_dir3;
    logic [4:0]  win_cell5;
    logic [1:0]  win_dir5;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttt_result_scanner #(.N(3), .K(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .board(board3),
        .busy(busy3), .done(done3), .status(status3)
`ifdef TTT_RESULT_LINE_REPORT_EN
        , .win_cell(win_cell3), .win_dir(win_dir3)
`endif
    );

    ttt_result_scanner #(.N(5), .K(4)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .board(board5),
        .busy(busy5), .done(done5), .status(status5)
`ifdef TTT_RESULT_LINE_REPORT_EN
        , .win_cell(win_cell5), .win_dir(win_dir5)
`endif
    );

    // Issues one scan on the 3x3 instance; lat = c where done is first seen
    // after edge T+c (T = accepting edge), or -1 on timeout.
    task automatic run3(input logic [17:0] b, output int lat);
        @(posedge clk); #1;
        board3 = b;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start3 = 1'b0; start5 = 1'b0; board3 = '0; board5 = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy3, done3, status3, busy5, done5, status5} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {busy3, done3, status3, busy5, done5, status5});
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if ({win_cell3, win_dir3, win_cell5, win_dir5} !== 13'h0) begin
            errors++;
            $display("FAIL reset_win_regs: got %h expected 0",
                     {win_cell3, win_dir3, win_cell5, win_dir5});
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_row_win();
        int lat;
        run3(18'b00_00_00_00_00_00_01_01_01, lat);
        checks++;
        if (lat !== 1 || status3 !== 2'b01 || busy3 !== 1'b1) begin
            errors++;
            $display("FAIL row_win: got lat=%0d status=%b busy=%b expected lat=1 status=01 busy=1",
                     lat, status3, busy3);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell3 !== 4'd0 || win_dir3 !== 2'b00) begin
            errors++;
            $display("FAIL row_win_line: got cell=%0d dir=%b expected cell=0 dir=00",
                     win_cell3, win_dir3);
        end
`endif
        @(posedge clk); #1;
        checks++;
        if (done3 !== 1'b0 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done3, busy3);
        end
        @(posedge clk); #1;
        checks++;
        if (status3 !== 2'b01) begin
            errors++;
            $display("FAIL status_hold: got %b expected 01", status3);
        end
    endtask

    task automatic test_directions();
        int lat;
        // cells 1,4,7 = P2: vertical win anchored at cell 1
        run3(18'b00_10_00_00_10_00_00_10_00, lat);
        checks++;
        if (lat !== 2 || status3 !== 2'b10) begin
            errors++;
            $display("FAIL down_win: got lat=%0d status=%b expected lat=2 status=10", lat, status3);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell3 !== 4'd1 || win_dir3 !== 2'b01) begin
            errors++;
            $display("FAIL down_win_line: got cell=%0d dir=%b expected cell=1 dir=01",
                     win_cell3, win_dir3);
        end
`endif
        // cells 0,4,8 = P1: main diagonal anchored at cell 0
        run3(18'b01_00_00_00_01_00_00_00_01, lat);
        checks++;
        if (lat !== 1 || status3 !== 2'b01) begin
            errors++;
            $display("FAIL diag_win: got lat=%0d status=%b expected lat=1 status=01", lat, status3);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell3 !== 4'd0 || win_dir3 !== 2'b10) begin
            errors++;
            $display("FAIL diag_win_line: got cell=%0d dir=%b expected cell=0 dir=10",
                     win_cell3, win_dir3);
        end
`endif
        // row of invalid marks with empties elsewhere: no result
        run3(18'b00_00_00_00_00_00_11_11_11, lat);
        checks++;
        if (lat !== 9 || status3 !== 2'b00) begin
            errors++;
            $display("FAIL invalid_row: got lat=%0d status=%b expected lat=9 status=00", lat, status3);
        end
        // all invalid: no line, no empty cell -> tie
        run3(18'h3FFFF, lat);
        checks++;
        if (lat !== 9 || status3 !== 2'b11) begin
            errors++;
            $display("FAIL all_invalid: got lat=%0d status=%b expected lat=9 status=11", lat, status3);
        end
    endtask

    task automatic test_tie_and_priority();
        int lat;
        // 01,10,01 / 01,10,10 / 10,01,01 : full, no line
        run3(18'b01_01_10_10_10_01_01_10_01, lat);
        checks++;
        if (lat !== 9 || status3 !== 2'b11) begin
            errors++;
            $display("FAIL tie: got lat=%0d status=%b expected lat=9 status=11", lat, status3);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell3 !== 4'd0 || win_dir3 !== 2'b00) begin
            errors++;
            $display("FAIL tie_line: got cell=%0d dir=%b expected 0 00", win_cell3, win_dir3);
        end
`endif
        // 01,10,01 / 01,01,10 / 10,10,10 : full, only bottom row wins
        run3(18'b10_10_10_10_01_01_01_10_01, lat);
        checks++;
        if (lat !== 7 || status3 !== 2'b10) begin
            errors++;
            $display("FAIL win_beats_tie: got lat=%0d status=%b expected lat=7 status=10", lat, status3);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell3 !== 4'd6 || win_dir3 !== 2'b00) begin
            errors++;
            $display("FAIL win_beats_tie_line: got cell=%0d dir=%b expected cell=6 dir=00",
                     win_cell3, win_dir3);
        end
`endif
    endtask

    task automatic test_large_board();
        int lat;
        @(posedge clk); #1;
        board5 = '0;
        board5[2*3  +: 2] = 2'b10;
        board5[2*7  +: 2] = 2'b10;
        board5[2*11 +: 2] = 2'b10;
        board5[2*15 +: 2] = 2'b10;
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done5 === 1'b1) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== 4 || status5 !== 2'b10) begin
            errors++;
            $display("FAIL n5_antidiag: got lat=%0d status=%b expected lat=4 status=10", lat, status5);
        end
`ifdef TTT_RESULT_LINE_REPORT_EN
        checks++;
        if (win_cell5 !== 5'd3 || win_dir5 !== 2'b11) begin
            errors++;
            $display("FAIL n5_antidiag_line: got cell=%0d dir=%b expected cell=3 dir=11",
                     win_cell5, win_dir5);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        board3 = '0;
        start3 = 1'b1;
        @(posedge clk); #1;          // edge T
        start3 = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (done3 === 1'b1) begin
                lat = c;
                break;
            end
            if (c == 1) start3 = 1'b1;            // sampled at T+2
            if (c == 2) begin
                start3 = 1'b0;
                board3 = 18'b00_00_00_00_00_00_01_01_01;  // visible at T+3
            end
        end
        checks++;
        if (lat !== 9 || status3 !== 2'b00) begin
            errors++;
            $display("FAIL ignore_start_board: got lat=%0d status=%b expected lat=9 status=00",
                     lat, status3);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL no_queued_scan: got busy=%b done=%b expected 0 0", busy3, done3);
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        @(posedge clk); #1;
        board3 = '0;
        start3 = 1'b1;
        @(posedge clk); #1;          // edge T
        start3 = 1'b0;
        repeat (2) @(posedge clk);   // edges T+1, T+2
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;          // edge T+3 samples reset
        checks++;
        if (busy3 !== 1'b0 || done3 !== 1'b0 || status3 !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b done=%b status=%b expected 0 0 00",
                     busy3, done3, status3);
        end
        rst_n = 1'b1;
        run3(18'b00_00_00_00_00_00_01_01_01, lat);
        checks++;
        if (lat !== 1 || status3 !== 2'b01) begin
            errors++;
            $display("FAIL rescan_after_reset: got lat=%0d status=%b expected lat=1 status=01",
                     lat, status3);
        end
    endtask

    initial begin
        test_reset();
        test_row_win();
        test_directions();
        test_tie_and_priority();
        test_large_board();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
